// File: rtl/det_pkg.sv
// Shared definitions for the determinant accelerator.
//   FP_MUL / FP_DIV / FP_MULSUB : opcodes presented on fp_op to the external FP unit
//   FP_ONE                      : IEEE-754 single-precision 1.0
//   det_state_e                 : elimination engine FSM states
//   rowcol_addr()               : matrixram address map {row, col}, row stride 32
package det_pkg;

   localparam logic [1:0]  FP_MUL    = 2'd0;
   localparam logic [1:0]  FP_DIV    = 2'd1;
   localparam logic [1:0]  FP_MULSUB = 2'd2;

   localparam logic [31:0] FP_ONE    = 32'h3F80_0000;

   typedef enum logic [3:0] {
      S_IDLE,
      S_PIV_RD,
      S_PIV_CHK,
      S_PIV_MUL,
      S_ROW_F_RD,
      S_ROW_F_DIV,
      S_EL_RD_IJ,
      S_EL_RD_KJ,
      S_EL_OP,
      S_EL_WR,
      S_FINISH
   } det_state_e;

   function automatic logic [9:0] rowcol_addr(input logic [4:0] row, input logic [4:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/det_index_gen.sv
// Pivot / row / column counters for in-place Gaussian elimination.
//   clk, reset    : clock, synchronous active-high reset
//   init_i        : load k = 0, i = 1, j = 1 (first pivot step)
//   adv_i         : step the (k, i, j) nest by one element write
//   last_idx_i    : n - 1 (five bits, n = 32 gives 31)
//   k_o, i_o, j_o : pivot row, current row, current column
//   row_done_o    : current element is the last of the row
//   step_done_o   : current element is the last of the pivot step
//   mat_done_o    : current pivot is the last pivot of the matrix
module det_index_gen (
   input  logic       clk,
   input  logic       reset,
   input  logic       init_i,
   input  logic       adv_i,
   input  logic [4:0] last_idx_i,
   output logic [4:0] k_o,
   output logic [4:0] i_o,
   output logic [4:0] j_o,
   output logic       row_done_o,
   output logic       step_done_o,
   output logic       mat_done_o
);

   logic [4:0] k_q, i_q, j_q;
   logic [4:0] k_d, i_d, j_d;
   logic       last_row;

   assign last_row    = (i_q == last_idx_i);
   assign row_done_o  = (j_q == last_idx_i);
   assign step_done_o = row_done_o && last_row;
   assign mat_done_o  = (k_q == last_idx_i);
   assign k_o = k_q;
   assign i_o = i_q;
   assign j_o = j_q;

   always_comb begin
      k_d = k_q;
      i_d = i_q;
      j_d = j_q;
      if (init_i) begin
         k_d = 5'd0;
         i_d = 5'd1;
         j_d = 5'd1;
      end else if (adv_i) begin
         if (!row_done_o) begin
            j_d = j_q + 5'd1;
         end else if (!last_row) begin
            i_d = i_q + 5'd1;
            j_d = k_q + 5'd1;
         end else begin
            k_d = k_q + 5'd1;
            // When the new pivot is the last one there are no rows below it;
            // park i/j on it so no counter ever passes n-1.
            if (k_q + 5'd1 == last_idx_i) begin
               i_d = k_q + 5'd1;
               j_d = k_q + 5'd1;
            end else begin
               i_d = k_q + 5'd2;
               j_d = k_q + 5'd2;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         k_q <= 5'd0;
         i_q <= 5'd1;
         j_q <= 5'd1;
      end else begin
         k_q <= k_d;
         i_q <= i_d;
         j_q <= j_d;
      end
   end

endmodule

// File: rtl/det_elim_engine.sv
// Determinant engine: in-place Gaussian elimination (no pivoting) on an N x N
// single-precision matrix in matrixram port B, one FP operation at a time.
//   clk, reset           : clock, synchronous active-high reset
//   start, n             : begin elimination on an n x n matrix (n clamped to MAX_N)
//   ram_addr/wdata/we    : matrixram port B request, address {row, col}
//   ram_rdata            : port B read data, RAM_LATENCY cycles after ram_addr
//   fp_op/a/b/c/start    : FP unit request (MUL a*b, DIV a/b, MULSUB c - a*b)
//   fp_result, fp_done   : FP unit response
//   busy, done           : run in progress / one-cycle completion pulse
//   det, singular        : product of pivots / zero pivot seen, held until next start
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | waiting for start
// PIV_RD     | read pivot a[k][k] (n = 0 exits to FINISH here)
// PIV_CHK    | zero pivot -> det = 0, singular, FINISH
// PIV_MUL    | det_acc = det_acc * p; last pivot -> FINISH
// ROW_F_RD   | read a[i][k]
// ROW_F_DIV  | f = a[i][k] / p
// EL_RD_IJ   | read a[i][j]
// EL_RD_KJ   | read a[k][j]
// EL_OP      | a[i][j] - f * a[k][j]
// EL_WR      | write result to a[i][j], advance indices
// FINISH     | done pulse, busy low
module det_elim_engine
   import det_pkg::*;
#(
   parameter int RAM_LATENCY = 2,
   parameter int MAX_N       = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  n,
   output logic [9:0]  ram_addr,
   output logic [31:0] ram_wdata,
   output logic        ram_we,
   input  logic [31:0] ram_rdata,
   output logic [1:0]  fp_op,
   output logic [31:0] fp_a,
   output logic [31:0] fp_b,
   output logic [31:0] fp_c,
   output logic        fp_start,
   input  logic [31:0] fp_result,
   input  logic        fp_done,
   output logic        busy,
   output logic        done,
   output logic [31:0] det,
   output logic        singular
);

   localparam int WW = (RAM_LATENCY < 2) ? 1 : $clog2(RAM_LATENCY + 1);

   det_state_e state_q, state_d;
   logic [WW-1:0] wait_q;
   logic          fp_pend_q;
   logic [5:0]    n_q;
   logic [31:0]   p_q, aik_q, f_q, aij_q, akj_q, res_q;
   logic [31:0]   det_acc_q, det_q;
   logic          singular_q;

   logic          rd_cap, fp_ack, piv_zero, idx_adv, idx_init;
   logic [4:0]    k_idx, i_idx, j_idx;
   logic          row_done, step_done, mat_done;

   assign rd_cap   = (wait_q == '0);
   // Only a response to our own outstanding request counts.
   assign fp_ack   = fp_done && fp_pend_q;
   assign piv_zero = (p_q[30:0] == 31'd0);
   assign idx_init = (state_q == S_IDLE) && start;

   assign busy     = (state_q != S_IDLE) && (state_q != S_FINISH);
   assign done     = (state_q == S_FINISH);
   assign det      = det_q;
   assign singular = singular_q;

   det_index_gen u_idx (
      .clk         (clk),
      .reset       (reset),
      .init_i      (idx_init),
      .adv_i       (idx_adv),
      .last_idx_i  (n_q[4:0] - 5'd1),
      .k_o         (k_idx),
      .i_o         (i_idx),
      .j_o         (j_idx),
      .row_done_o  (row_done),
      .step_done_o (step_done),
      .mat_done_o  (mat_done)
   );

   always_comb begin
      state_d   = state_q;
      ram_addr  = 10'd0;
      ram_wdata = 32'd0;
      ram_we    = 1'b0;
      fp_op     = FP_MUL;
      fp_a      = 32'd0;
      fp_b      = 32'd0;
      fp_c      = 32'd0;
      fp_start  = 1'b0;
      idx_adv   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_PIV_RD;
         end
         S_PIV_RD: begin
            if (n_q == 6'd0) begin
               state_d = S_FINISH;
            end else begin
               ram_addr = rowcol_addr(k_idx, k_idx);
               if (rd_cap) state_d = S_PIV_CHK;
            end
         end
         S_PIV_CHK: begin
            state_d = piv_zero ? S_FINISH : S_PIV_MUL;
         end
         S_PIV_MUL: begin
            fp_op    = FP_MUL;
            fp_a     = det_acc_q;
            fp_b     = p_q;
            fp_start = !fp_pend_q;
            if (fp_ack) state_d = mat_done ? S_FINISH : S_ROW_F_RD;
         end
         S_ROW_F_RD: begin
            ram_addr = rowcol_addr(i_idx, k_idx);
            if (rd_cap) state_d = S_ROW_F_DIV;
         end
         S_ROW_F_DIV: begin
            fp_op    = FP_DIV;
            fp_a     = aik_q;
            fp_b     = p_q;
            fp_start = !fp_pend_q;
            if (fp_ack) state_d = S_EL_RD_IJ;
         end
         S_EL_RD_IJ: begin
            ram_addr = rowcol_addr(i_idx, j_idx);
            if (rd_cap) state_d = S_EL_RD_KJ;
         end
         S_EL_RD_KJ: begin
            ram_addr = rowcol_addr(k_idx, j_idx);
            if (rd_cap) state_d = S_EL_OP;
         end
         S_EL_OP: begin
            fp_op    = FP_MULSUB;
            fp_a     = f_q;
            fp_b     = akj_q;
            fp_c     = aij_q;
            fp_start = !fp_pend_q;
            if (fp_ack) state_d = S_EL_WR;
         end
         S_EL_WR: begin
            ram_addr  = rowcol_addr(i_idx, j_idx);
            ram_wdata = res_q;
            ram_we    = 1'b1;
            idx_adv   = 1'b1;
            if (step_done)     state_d = S_PIV_RD;
            else if (row_done) state_d = S_ROW_F_RD;
            else               state_d = S_EL_RD_IJ;
         end
         S_FINISH: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         wait_q     <= '0;
         fp_pend_q  <= 1'b0;
         n_q        <= 6'd0;
         p_q        <= 32'd0;
         aik_q      <= 32'd0;
         f_q        <= 32'd0;
         aij_q      <= 32'd0;
         akj_q      <= 32'd0;
         res_q      <= 32'd0;
         det_acc_q  <= FP_ONE;
         det_q      <= FP_ONE;
         singular_q <= 1'b0;
      end else begin
         state_q <= state_d;
         // Read wait timer restarts on every state change so each read state
         // captures exactly RAM_LATENCY cycles after it first drives ram_addr.
         if (state_d != state_q)  wait_q <= WW'(RAM_LATENCY);
         else if (wait_q != '0)   wait_q <= wait_q - WW'(1);

         if (fp_start)    fp_pend_q <= 1'b1;
         else if (fp_ack) fp_pend_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (start) begin
                  n_q        <= (n > 6'(MAX_N)) ? 6'(MAX_N) : n;
                  det_acc_q  <= FP_ONE;
                  det_q      <= FP_ONE;
                  singular_q <= 1'b0;
               end
            end
            S_PIV_RD:    if (rd_cap) p_q <= ram_rdata;
            S_PIV_CHK: begin
               if (piv_zero) begin
                  det_q      <= 32'd0;
                  singular_q <= 1'b1;
               end
            end
            S_PIV_MUL: begin
               if (fp_ack) begin
                  det_acc_q <= fp_result;
                  if (mat_done) det_q <= fp_result;
               end
            end
            S_ROW_F_RD:  if (rd_cap) aik_q <= ram_rdata;
            S_ROW_F_DIV: if (fp_ack) f_q   <= fp_result;
            S_EL_RD_IJ:  if (rd_cap) aij_q <= ram_rdata;
            S_EL_RD_KJ:  if (rd_cap) akj_q <= ram_rdata;
            S_EL_OP:     if (fp_ack) res_q <= fp_result;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_det_elim_engine.sv
// Self-checking bench for det_elim_engine: 2-cycle RAM model, 3-cycle FP model,
// and a plain Gaussian-elimination reference for randomized matrices.
module tb_det_elim_engine;
   import det_pkg::*;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [5:0]  n;
   logic [9:0]  ram_addr;
   logic [31:0] ram_wdata, ram_rdata;
   logic        ram_we;
   logic [1:0]  fp_op;
   logic [31:0] fp_a, fp_b, fp_c, fp_result;
   logic        fp_start, fp_done;
   logic        busy, done, singular;
   logic [31:0] det;

   always #5 clk = ~clk;

   det_elim_engine #(.RAM_LATENCY(2), .MAX_N(32)) dut (
      .clk(clk), .reset(reset), .start(start), .n(n),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
      .fp_op(fp_op), .fp_a(fp_a), .fp_b(fp_b), .fp_c(fp_c), .fp_start(fp_start),
      .fp_result(fp_result), .fp_done(fp_done),
      .busy(busy), .done(done), .det(det), .singular(singular)
   );

   int n_cmp = 0;
   int n_mis = 0;

   // ---------------- FP helpers (single <-> double by bit manipulation) ----
   function automatic real s2r(input logic [31:0] s);
      logic [63:0] d;
      if (s[30:23] == 8'd0) d = {s[31], 63'd0};
      else d = {s[31], {3'b000, s[30:23]} + 11'd896, s[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2s(input real r);
      logic [63:0] d;
      int          e;
      logic [31:0] v;
      logic        up;
      d = $realtobits(r);
      e = int'(d[62:52]) - 896;
      if (e <= 0)   return {d[63], 31'd0};
      if (e >= 255) return {d[63], 8'hFF, 23'd0};
      up = (d[28:0] > 29'h1000_0000) || ((d[28:0] == 29'h1000_0000) && d[29]);
      v = {1'b0, 8'(e), d[51:29]} + {31'd0, up};
      return {d[63], v[30:0]};
   endfunction

   function automatic logic [31:0] fp_calc(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] c);
      case (op)
         FP_MUL:    return r2s(s2r(a) * s2r(b));
         FP_DIV:    return r2s(s2r(a) / s2r(b));
         default:   return r2s(s2r(c) - s2r(a) * s2r(b));
      endcase
   endfunction

   // ---------------- RAM model, latency 2 ----------------------------------
   logic [31:0] mem [1024];
   logic [31:0] rd_p1, rd_p2;
   logic        ld_en;
   logic [9:0]  ld_addr;
   logic [31:0] ld_data;
   int          wr_total = 0;
   int          done_total = 0;

   assign ram_rdata = rd_p2;

   always @(posedge clk) begin
      if (ld_en)       mem[ld_addr] <= ld_data;
      else if (ram_we) mem[ram_addr] <= ram_wdata;
      rd_p1 <= mem[ram_addr];
      rd_p2 <= rd_p1;
      if (ram_we) wr_total <= wr_total + 1;
      if (done)   done_total <= done_total + 1;
   end

   // ---------------- FP unit model, latency 3 ------------------------------
   logic [1:0]  m_op;
   logic [31:0] m_a, m_b, m_c;
   int          m_cnt = 0;
   int          proto_err = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_cnt   <= 0;
         fp_done <= 1'b0;
      end else begin
         fp_done <= 1'b0;
         if (fp_start) begin
            if (m_cnt != 0) proto_err <= proto_err + 1;
            m_op <= fp_op; m_a <= fp_a; m_b <= fp_b; m_c <= fp_c;
            m_cnt <= 2;
         end else if (m_cnt != 0) begin
            if (fp_op !== m_op || fp_a !== m_a || fp_b !== m_b || fp_c !== m_c)
               proto_err <= proto_err + 1;
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
               fp_done   <= 1'b1;
               fp_result <= fp_calc(m_op, m_a, m_b, m_c);
            end
         end
      end
   end

   // ---------------- stimulus / reference ----------------------------------
   logic [31:0] mat   [32][32];
   logic [31:0] ref_a [32][32];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void ref_elim(input int nn, output logic [31:0] det_e,
                                    output logic sing_e, output int wr_e);
      logic [31:0] p, f;
      det_e = FP_ONE; sing_e = 1'b0; wr_e = 0;
      for (int r = 0; r < 32; r++)
         for (int c = 0; c < 32; c++) ref_a[r][c] = mat[r][c];
      for (int k = 0; k < nn; k++) begin
         p = ref_a[k][k];
         if (p[30:0] == 31'd0) begin
            det_e = 32'd0; sing_e = 1'b1;
            return;
         end
         det_e = fp_calc(FP_MUL, det_e, p, 32'd0);
         for (int i = k + 1; i < nn; i++) begin
            f = fp_calc(FP_DIV, ref_a[i][k], p, 32'd0);
            for (int j = k + 1; j < nn; j++) begin
               ref_a[i][j] = fp_calc(FP_MULSUB, f, ref_a[k][j], ref_a[i][j]);
               wr_e++;
            end
         end
      end
   endfunction

   task automatic load_mat(input int nn);
      for (int r = 0; r < nn; r++)
         for (int c = 0; c < nn; c++) begin
            ld_en = 1'b1; ld_addr = rowcol_addr(5'(r), 5'(c)); ld_data = mat[r][c];
            @(posedge clk); #1;
         end
      ld_en = 1'b0;
   endtask

   task automatic rand_mat(input int nn);
      for (int r = 0; r < nn; r++)
         for (int c = 0; c < nn; c++)
            if (r == c) mat[r][c] = r2s(real'(int'($urandom_range(8)) + 1));
            else        mat[r][c] = r2s(real'(int'($urandom_range(16)) - 8));
   endtask

   task automatic run(input string tag, input int nn, input int extra_at, output int lat);
      start = 1'b1; n = 6'(nn);
      @(posedge clk); #1;
      start = 1'b0; lat = 1;
      while (done !== 1'b1 && lat < 5000) begin
         if (lat == extra_at) chk({tag, "_busy_at_restart"}, 32'(busy), 32'd1);
         start = (lat == extra_at);
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_done_pulse"}, 32'(done), 32'd0);
   endtask

   task automatic check_ref(input string tag, input int nn, input int w0);
      logic [31:0] de;
      logic        se;
      int          we, bad;
      ref_elim(nn, de, se, we);
      chk({tag, "_det"}, det, de);
      chk({tag, "_sing"}, 32'(singular), 32'(se));
      chk({tag, "_writes"}, 32'(wr_total - w0), 32'(we));
      bad = 0;
      for (int r = 0; r < nn; r++)
         for (int c = 0; c < nn; c++)
            if (mem[rowcol_addr(5'(r), 5'(c))] !== ref_a[r][c]) bad++;
      chk({tag, "_mem_bad"}, 32'(bad), 32'd0);
   endtask

   initial begin
      int lat, w0, d0, wr1, nn;
      logic [31:0] det1;
      logic found;

      reset = 1'b1; start = 1'b0; n = 6'd0;
      ld_en = 1'b0; ld_addr = 10'd0; ld_data = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_det", det, FP_ONE);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_sing", 32'(singular), 32'd0);
      chk("rst_we_fpstart", {30'd0, ram_we, fp_start}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // 2x2 [[1,2],[3,4]]
      mat[0][0] = 32'h3F80_0000; mat[0][1] = 32'h4000_0000;
      mat[1][0] = 32'h4040_0000; mat[1][1] = 32'h4080_0000;
      load_mat(2);
      w0 = wr_total; d0 = done_total;
      run("A", 2, -1, lat);
      chk("A_det", det, 32'hC000_0000);
      chk("A_sing", 32'(singular), 32'd0);
      chk("A_writes", 32'(wr_total - w0), 32'd1);
      chk("A_a11", mem[rowcol_addr(5'd1, 5'd1)], 32'hC000_0000);

      // 3x3 diag(2,3,4)
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++) mat[r][c] = 32'd0;
      mat[0][0] = 32'h4000_0000; mat[1][1] = 32'h4040_0000; mat[2][2] = 32'h4080_0000;
      load_mat(3);
      w0 = wr_total; d0 = done_total;
      run("B", 3, -1, lat);
      chk("B_det", det, 32'h41C0_0000);
      chk("B_writes", 32'(wr_total - w0), 32'd5);
      chk("B_done_count", 32'(done_total - d0), 32'd1);
      chk("B_busy_after", 32'(busy), 32'd0);

      // zero pivot
      mat[0][0] = 32'd0;         mat[0][1] = 32'h3F80_0000;
      mat[1][0] = 32'h3F80_0000; mat[1][1] = 32'd0;
      load_mat(2);
      w0 = wr_total;
      run("C", 2, -1, lat);
      chk("C_det", det, 32'd0);
      chk("C_sing", 32'(singular), 32'd1);
      chk("C_writes", 32'(wr_total - w0), 32'd0);
      chk("C_latency_le8", 32'(lat <= 8), 32'd1);

      // n = 0
      w0 = wr_total;
      run("D", 0, -1, lat);
      chk("D_latency", 32'(lat), 32'd2);
      chk("D_det", det, FP_ONE);
      chk("D_sing", 32'(singular), 32'd0);
      chk("D_writes", 32'(wr_total - w0), 32'd0);

      // n = 1
      mat[0][0] = 32'h40A0_0000;
      load_mat(1);
      w0 = wr_total;
      run("E", 1, -1, lat);
      chk("E_det", det, 32'h40A0_0000);
      chk("E_writes", 32'(wr_total - w0), 32'd0);

      // second start while busy must be ignored
      rand_mat(3);
      load_mat(3);
      w0 = wr_total;
      run("F1", 3, -1, lat);
      check_ref("F1", 3, w0);
      det1 = det; wr1 = wr_total - w0;
      load_mat(3);
      w0 = wr_total; d0 = done_total;
      run("F2", 3, 10, lat);
      check_ref("F2", 3, w0);
      chk("F2_det_vs_single", det, det1);
      chk("F2_writes_vs_single", 32'(wr_total - w0), 32'(wr1));
      chk("F2_done_count", 32'(done_total - d0), 32'd1);

      // reset during EL_OP
      rand_mat(3);
      load_mat(3);
      start = 1'b1; n = 6'd3;
      @(posedge clk); #1;
      start = 1'b0; lat = 1; found = 1'b0;
      while (!found && lat < 2000) begin
         if (fp_start === 1'b1 && fp_op === FP_MULSUB) found = 1'b1;
         else begin
            @(posedge clk); #1;
            lat++;
         end
      end
      chk("G_reached_el_op", 32'(found), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("G_busy", 32'(busy), 32'd0);
      chk("G_fp_start", 32'(fp_start), 32'd0);
      chk("G_ram_we", 32'(ram_we), 32'd0);
      chk("G_det", det, FP_ONE);
      reset = 1'b0;
      @(posedge clk); #1;
      load_mat(3);
      w0 = wr_total;
      run("G2", 3, -1, lat);
      check_ref("G2", 3, w0);

      // randomized sizes
      for (int t = 0; t < 6; t++) begin
         nn = int'($urandom_range(4)) + 2;
         rand_mat(nn);
         load_mat(nn);
         w0 = wr_total;
         run($sformatf("R%0d", t), nn, -1, lat);
         check_ref($sformatf("R%0d", t), nn, w0);
      end

      chk("fp_protocol_errors", 32'(proto_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/det_elim_engine.md
Name: det_elim_engine

Overview:
- Downstream compute stage of the determinant accelerator. Starts when the DMA stage finishes loading the N×N IEEE-754 single-precision matrix into matrixram.
- Runs Gaussian elimination without pivoting, in place, through RAM port B. Arithmetic is issued one operation at a time to an external FP unit.
- Returns the determinant (product of pivots) and a done pulse to the CPU-interface logic, which uses it as its done signal.

Parameters:
- RAM_LATENCY, 2: cycles from ram_addr valid to ram_rdata valid (matrixram read latency).
- MAX_N, 32: maximum matrix dimension; also the row stride of the RAM address map (addr = row*32 + col).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: matrix is loaded, begin elimination
- n  in  6  matrix dimension; sampled on start; values above 32 are treated as 32
- ram_addr  out  10  matrixram port B address, {row[4:0], col[4:0]}
- ram_wdata  out  32  port B write data
- ram_we  out  1  port B write enable
- ram_rdata  in  32  port B read data
- fp_op  out  2  operation: 0 = MUL (a*b), 1 = DIV (a/b), 2 = MULSUB (c − a*b)
- fp_a, fp_b, fp_c  out  32 each  FP operands
- fp_start  out  1  one-cycle request pulse
- fp_result  in  32  FP result
- fp_done  in  1  one-cycle pulse; fp_result is valid in the same cycle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- det  out  32  determinant; held until the next start
- singular  out  1  zero pivot was encountered; held until the next start

Behaviour:
- Reset values: all outputs 0, except det = 0x3F800000 (1.0). FSM goes to IDLE. A reset mid-operation aborts immediately; no further RAM writes or fp_start.
- start is accepted only in IDLE and ignored while busy. On accept: latch n (clamped), set det_acc = 1.0, clear singular, k = 0.
- FSM states: IDLE → PIV_RD → PIV_CHK → PIV_MUL → ROW_F_RD → ROW_F_DIV → EL_RD_IJ → EL_RD_KJ → EL_OP → EL_WR → (loop) → FINISH → IDLE.
- Every *_RD state drives ram_addr and waits exactly RAM_LATENCY cycles before capturing ram_rdata.
- Every FP state pulses fp_start for one cycle, holds the operands stable, and waits for fp_done. An fp_done arriving in any other state is ignored.
- PIV_RD: read p = a[k][k].
- PIV_CHK: if p[30:0] == 0 (±0), set det = 0 and singular = 1, then go to FINISH. No pivoting is performed.
- PIV_MUL: det_acc = MUL(det_acc, p).
- Row loop, for i = k+1..n−1:
  - ROW_F_RD: read a[i][k].
  - ROW_F_DIV: f = DIV(a[i][k], p).
  - Element loop, for j = k+1..n−1: read a[i][j] and a[k][j]; compute MULSUB(c = a[i][j], a = f, b = a[k][j]); EL_WR writes the result to a[i][j] with ram_we high for 1 cycle.
- Column k of rows below the pivot is never rewritten; it is not needed afterwards.
- After the last row of step k: k = k+1. If k == n, go to FINISH; otherwise go to PIV_RD.
- FINISH: det = det_acc (unless singular), done = 1 for one cycle, busy drops in the same cycle.
- Special sizes:
  - n = 0: done 2 cycles after start, det = 1.0, no RAM access.
  - n = 1: det = a[0][0] after one MUL; no writes.
- RAM writes per run = Σ_{k=0}^{n−2} (n−1−k)². This count is a checkable invariant.
- Index counters k, i, j are 5 bits. Address = {row, col}. Counters never exceed n−1, so there is no wrap-around.
- ram_we is never asserted in the same cycle as a read capture. Port B is used exclusively by this block while busy.

Decomposition:
- Shared package det_pkg:
  - FP opcode constants (FP_MUL, FP_DIV, FP_MULSUB)
  - FP_ONE = 0x3F800000
  - FSM state enum
  - rowcol-to-address function, shared with the DMA stage
- One sub-module, det_index_gen: holds the k/i/j counters with first/last flags, steps on a one-cycle advance input, and reports row-done and matrix-done. The FSM and the wait counters stay in det_elim_engine.

Test Plan (bench uses a behavioural FP model with fixed 3-cycle latency and a RAM model with RAM_LATENCY = 2):
- n = 2, [[1,2],[3,4]] → det = 0xC0000000 (−2.0), singular = 0, exactly 1 RAM write, a[1][1] becomes 0xC0000000.
- n = 3, [[2,0,0],[0,3,0],[0,0,4]] → det = 0x41C00000 (24.0), 5 RAM writes, one done pulse, busy low afterwards.
- n = 2, [[0,1],[1,0]] → det = 0, singular = 1, no RAM writes, done within 8 cycles of start.
- n = 0 → det = 0x3F800000, done 2 cycles after start. n = 1 with a[0][0] = 0x40A00000 → det = 0x40A00000.
- Second start pulse while busy during an n = 3 run → ignored; result and write count match the single-start run.
- Reset asserted mid-run during EL_OP → next cycle: busy = 0, fp_start = 0, ram_we = 0, det = 1.0. A fresh start then completes correctly.
